// File: rtl/alu_exec_unit_if.sv
// Request/result bus of the ALU execute unit: operands and op code in, registered result out.
interface alu_exec_unit_if;
  logic [2:0]  ALUCtrl_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        valid_i;
  logic        ready_o;
  logic        flush_i;
  logic [31:0] data_o;
  logic        zero_o;
  logic        valid_o;
  logic        ready_i;

  modport master (
    output ALUCtrl_i, data1_i, data2_i, valid_i, flush_i, ready_i,
    input  ready_o, data_o, zero_o, valid_o
  );

  modport slave (
    input  ALUCtrl_i, data1_i, data2_i, valid_i, flush_i, ready_i,
    output ready_o, data_o, zero_o, valid_o
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops, 32-step shift-add multiply,
// result held until the consumer takes it.
module alu_exec_unit (
  input  logic             clk_i,
  input  logic             rst_i,
  alu_exec_unit_if.slave   bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_mcand, w_mcand_nxt;
  logic [W-1:0]    r_mplier, w_mplier_nxt;
  logic [W-1:0]    r_acc, w_acc_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [W-1:0]    r_data, w_data_nxt;
  logic            r_zero, w_zero_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_ready, w_ready_nxt;
  logic [W-1:0]    w_alu;
  logic [W-1:0]    w_sum;

  // Single-cycle result; MUL and the reserved code both produce 0 here.
  always_comb begin
    w_alu = '0;
    unique case (bus.ALUCtrl_i)
      3'b000:  w_alu = bus.data1_i & bus.data2_i;
      3'b010:  w_alu = bus.data1_i + bus.data2_i;
      3'b100:  w_alu = bus.data1_i ^ bus.data2_i;
      3'b101:  w_alu = bus.data1_i << bus.data2_i[4:0];
      3'b110:  w_alu = bus.data1_i - bus.data2_i;
      3'b111:  w_alu = W'($signed(bus.data1_i) >>> bus.data2_i[4:0]);
      default: w_alu = '0;
    endcase
  end

  assign w_sum = r_acc + (r_mplier[0] ? r_mcand : W'(0));

  always_comb begin
    w_state_nxt  = r_state;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_data_nxt   = r_data;
    w_zero_nxt   = r_zero;

    unique case (r_state)
      S_IDLE: begin
        if (bus.valid_i && r_ready) begin
          if (bus.ALUCtrl_i == 3'b011) begin
            w_mcand_nxt  = bus.data1_i;
            w_mplier_nxt = bus.data2_i;
            w_acc_nxt    = '0;
            w_cnt_nxt    = '0;
            w_state_nxt  = S_MUL;
          end else begin
            w_data_nxt  = w_alu;
            w_zero_nxt  = (w_alu == '0);
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_MUL: begin
        w_acc_nxt    = w_sum;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = r_cnt + CW'(1);
        if (r_cnt == CW'(W - 1)) begin
          w_data_nxt  = w_sum;
          w_zero_nxt  = (w_sum == '0);
          w_cnt_nxt   = '0;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Flush overrides everything; the last delivered result stays on data_o.
    if (bus.flush_i) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_data_nxt  = r_data;
      w_zero_nxt  = r_zero;
    end

    w_valid_nxt = (w_state_nxt == S_HOLD);
    w_ready_nxt = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_zero   <= 1'b1;
      r_valid  <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_data   <= w_data_nxt;
      r_zero   <= w_zero_nxt;
      r_valid  <= w_valid_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  assign bus.data_o  = r_data;
  assign bus.zero_o  = r_zero;
  assign bus.valid_o = r_valid;
  assign bus.ready_o = r_ready;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: stimulus pushes expected results, a negedge monitor
// pops and compares them on every result handshake.
module tb_alu_exec_unit;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  alu_exec_unit_if u_if();

  alu_exec_unit dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (u_if)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        z;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
  endtask

  // Result monitor: a transfer happens on the next edge whenever valid_o && ready_i.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (rst_i && u_if.valid_o && u_if.ready_i && !u_if.flush_i) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got result 0x%08h want no result", u_if.data_o);
      end else begin
        e = sb_q.pop_front();
        check("sb_data", u_if.data_o, e.d);
        check("sb_zero", {31'b0, u_if.zero_o}, {31'b0, e.z});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    while (!u_if.ready_o && w < 50) begin
      tick();
      w++;
    end
    check("accept_ready", {31'b0, u_if.ready_o}, 32'd1);
    u_if.ALUCtrl_i = op;
    u_if.data1_i   = a;
    u_if.data2_i   = b;
    u_if.valid_i   = 1'b1;
    tick();
    u_if.valid_i   = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input int hold);
    int   n = 1;
    logic rdy_seen = 1'b0;
    sb_q.push_back({exp, (exp == 32'd0)});
    u_if.ready_i = 1'b0;
    accept(op, a, b);
    while (!u_if.valid_o && n < 100) begin
      rdy_seen |= u_if.ready_o;
      tick();
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(lat));
    check({name, "_busy_ready"}, {31'b0, rdy_seen | u_if.ready_o}, 32'd0);
    repeat (hold) begin
      tick();
      check({name, "_hold_valid"}, {31'b0, u_if.valid_o}, 32'd1);
      check({name, "_hold_data"}, u_if.data_o, exp);
    end
    u_if.ready_i = 1'b1;
    tick();
    u_if.ready_i = 1'b0;
    check({name, "_release_valid"}, {31'b0, u_if.valid_o}, 32'd0);
    check({name, "_release_ready"}, {31'b0, u_if.ready_o}, 32'd1);
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    logic seen = 1'b0;
    repeat (cycles) begin
      tick();
      seen |= u_if.valid_o;
    end
    check(name, {31'b0, seen}, 32'd0);
  endtask

  initial begin
    u_if.ALUCtrl_i = 3'b000;
    u_if.data1_i   = '0;
    u_if.data2_i   = '0;
    u_if.valid_i   = 1'b0;
    u_if.flush_i   = 1'b0;
    u_if.ready_i   = 1'b0;

    // Reset state
    #12;
    check("rst_ready", {31'b0, u_if.ready_o}, 32'd0);
    check("rst_valid", {31'b0, u_if.valid_o}, 32'd0);
    check("rst_data", u_if.data_o, 32'd0);
    check("rst_zero", {31'b0, u_if.zero_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check("rst_release_ready_before_edge", {31'b0, u_if.ready_o}, 32'd0);
    tick();
    check("rst_release_ready", {31'b0, u_if.ready_o}, 32'd1);

    // Single-cycle ops
    run_op("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0);
    run_op("sub",      3'b110, 32'd5,         32'd7,         32'hFFFF_FFFE, 1, 0);
    run_op("sra",      3'b111, 32'h8000_0000, 32'd4,         32'hF800_0000, 1, 0);
    run_op("sll",      3'b101, 32'h0000_0001, 32'd31,        32'h8000_0000, 1, 0);
    run_op("sll_amt5", 3'b101, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1, 0);
    run_op("xor",      3'b100, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1, 0);
    run_op("resv",     3'b001, 32'h1234_5678, 32'h0000_5678, 32'h0000_0000, 1, 0);
    run_op("add_hold", 3'b010, 32'h0000_1000, 32'h0000_0234, 32'h0000_1234, 1, 5);

    // Iterative multiply
    run_op("mul_ff",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 5);
    run_op("mul_dec", 3'b011, 32'd12345,     32'd1000,      32'h00BC_5EA8, 33, 0);

    // Flush at multiply iteration 10
    accept(3'b011, 32'd3, 32'd4);
    repeat (9) tick();
    u_if.flush_i = 1'b1;
    tick();
    u_if.flush_i = 1'b0;
    check("flush_mul_valid", {31'b0, u_if.valid_o}, 32'd0);
    check("flush_mul_ready", {31'b0, u_if.ready_o}, 32'd1);
    check("flush_mul_data_kept", u_if.data_o, 32'h00BC_5EA8);
    watch_no_valid("flush_mul_no_valid", 40);
    run_op("and", 3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1, 0);

    // Flush coincident with a request in IDLE: request dropped
    u_if.ALUCtrl_i = 3'b010;
    u_if.data1_i   = 32'd1;
    u_if.data2_i   = 32'd1;
    u_if.valid_i   = 1'b1;
    u_if.flush_i   = 1'b1;
    tick();
    u_if.valid_i   = 1'b0;
    u_if.flush_i   = 1'b0;
    check("flush_idle_ready", {31'b0, u_if.ready_o}, 32'd1);
    watch_no_valid("flush_idle_no_valid", 4);
    check("flush_idle_data_kept", u_if.data_o, 32'h00F0_00F0);

    // Flush coincident with ready_i in HOLD: result discarded
    accept(3'b010, 32'd2, 32'd2);
    check("flush_hold_valid_before", {31'b0, u_if.valid_o}, 32'd1);
    u_if.ready_i = 1'b1;
    u_if.flush_i = 1'b1;
    tick();
    u_if.ready_i = 1'b0;
    u_if.flush_i = 1'b0;
    check("flush_hold_valid", {31'b0, u_if.valid_o}, 32'd0);
    check("flush_hold_ready", {31'b0, u_if.ready_o}, 32'd1);

    // Asynchronous reset mid-multiply
    accept(3'b011, 32'd7, 32'd9);
    repeat (5) tick();
    #2;
    rst_i = 1'b0;
    #1;
    check("arst_valid", {31'b0, u_if.valid_o}, 32'd0);
    check("arst_data", u_if.data_o, 32'd0);
    check("arst_zero", {31'b0, u_if.zero_o}, 32'd1);
    check("arst_ready", {31'b0, u_if.ready_o}, 32'd0);
    #2;
    rst_i = 1'b1;
    tick();
    check("arst_release_ready", {31'b0, u_if.ready_o}, 32'd1);
    watch_no_valid("arst_no_valid", 40);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion want completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  asynchronous active-low reset.
REQ-004 ALUCtrl_i  input  3  operation code from the ALU control stage.
REQ-005 data1_i  input  32  operand A (rs1).
REQ-006 data2_i  input  32  operand B (rs2 or immediate).
REQ-007 valid_i  input  1  operation request; operands and ALUCtrl_i valid this cycle.
REQ-008 ready_o  output  1  block can accept a request this cycle.
REQ-009 flush_i  input  1  synchronous abort of any in-flight or held operation.
REQ-010 data_o  output  32  registered result.
REQ-011 zero_o  output  1  registered; 1 iff data_o == 0.
REQ-012 valid_o  output  1  data_o/zero_o valid.
REQ-013 ready_i  input  1  downstream accepts result this cycle.

Function
REQ-014 Op map: 000 AND; 010 ADD; 011 MUL (low 32 bits, iterative); 100 XOR; 101 SLL; 110 SUB; 111 SRA (arithmetic); 001 reserved -> result 0, single-cycle.
REQ-015 Shift amount SHALL be data2_i[4:0]; ADD/SUB wrap modulo 2^32, no overflow flag.
REQ-016 States: IDLE, MUL, HOLD.
REQ-017 Request accepted when valid_i && ready_o on a rising edge; operands and code latched then.
REQ-018 ready_o SHALL be 1 only in IDLE.
REQ-019 IDLE, accept non-MUL: result registered same edge, go HOLD; valid_o=1 next cycle (latency 1).
REQ-020 IDLE, accept MUL: load multiplicand=data1_i, multiplier=data2_i, accumulator=0, counter=0; go MUL.
REQ-021 MUL: each cycle, if multiplier[0] add multiplicand to accumulator; multiplicand <<1; multiplier >>1 (logical); counter+1.
REQ-022 MUL SHALL perform exactly 32 iterations; on the 32nd, final accumulator registered to data_o, go HOLD; valid_o=1 33 cycles after accept edge.
REQ-023 HOLD: valid_o=1, data_o/zero_o stable until valid_o && ready_i; then go IDLE, valid_o=0 next cycle.
REQ-024 No acceptance in the HOLD-release cycle (ready_o=0 in HOLD); back-to-back throughput is one op per 2 cycles for single-cycle ops.
REQ-025 Counter SHALL be 6 bits; no wrap possible before exit at 32.
REQ-026 flush_i=1 SHALL, next edge, force IDLE, valid_o=0, counter=0, regardless of state; data_o retains last value.
REQ-027 flush_i coincident with valid_i in IDLE: flush wins, request dropped.
REQ-028 flush_i coincident with ready_i in HOLD: result discarded, IDLE (same outcome).
REQ-029 valid_i with unsupported timing (ready_o=0) SHALL be ignored; no internal buffering.
REQ-030 zero_o SHALL be computed from the registered result, never from in-progress accumulator.

Reset
REQ-031 rst_i low SHALL immediately force IDLE, data_o=0, zero_o=1, valid_o=0, counter=0, accumulator=0.
REQ-032 ready_o SHALL be 0 while rst_i is low and 1 from the first edge after deassertion.
REQ-033 Reset mid-MUL or in HOLD SHALL abandon the operation without any valid_o pulse.

Verification
REQ-034 ADD 0xFFFFFFFF + 0x00000001 -> data_o=0, zero_o=1, valid_o 1 cycle after accept.
REQ-035 SUB 5 - 7 -> 0xFFFFFFFE, zero_o=0; SRA 0x80000000 by 4 -> 0xF8000000; SLL 1 by 31 -> 0x80000000.
REQ-036 MUL 0xFFFFFFFF * 0xFFFFFFFF -> 0x00000001 exactly 33 cycles after accept; ready_o=0 throughout.
REQ-037 HOLD with ready_i=0 for 5 cycles -> data_o and valid_o unchanged; ready_i=1 -> valid_o=0, ready_o=1 next cycle.
REQ-038 flush_i at MUL iteration 10 -> IDLE next cycle, no valid_o; following AND 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0.
REQ-039 rst_i asserted mid-MUL (asynchronous, between edges) -> valid_o=0, data_o=0, zero_o=1 immediately.
